// File: rtl/wrapper_video_frontend.sv
// wrapper_video_frontend: pixel clock-enable, debounced keys and registered, widened video between board pins and a core.
// Define WRAPPER_VIDEO_FRONTEND_BLANK_EN to force rgb to black whenever core sync is active.
module wrapper_video_frontend #(
   parameter int CLK_DIV    = 2,
   parameter int NKEYS      = 4,
   parameter int DEB_CYCLES = 16,
   parameter int IN_BPC     = 1,
   parameter int OUT_BPC    = 4,
   parameter bit SYNC_IDLE  = 1'b1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [NKEYS-1:0]     keys_in,
   output logic                 pix_en,
   output logic [NKEYS-1:0]     keys_level,
   output logic [NKEYS-1:0]     keys_press,
   input  logic                 core_hsync,
   input  logic                 core_vsync,
   input  logic [3*IN_BPC-1:0]  core_rgb,
   output logic                 hsync,
   output logic                 vsync,
   output logic [3*OUT_BPC-1:0] rgb,
   output logic                 frame_start
);
   localparam int CW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
   localparam int DW = $clog2(DEB_CYCLES + 1);
   localparam logic [CW-1:0] CMAX  = CW'(CLK_DIV - 1);
   localparam logic [DW-1:0] DLAST = DW'(DEB_CYCLES - 1);

   logic [CW-1:0] cnt;
   logic [NKEYS-1:0] sync1, sync2, flip;
   logic [DW-1:0] deb [NKEYS];
   logic [3*OUT_BPC-1:0] wide;
   logic blank, vsync_d;

   always_ff @(posedge clk) begin
      if (!reset) begin
         cnt    <= '0;
         pix_en <= 1'b0;
      end else begin
         cnt    <= (cnt == CMAX) ? '0 : cnt + 1'b1;
         pix_en <= cnt == CMAX;
      end
   end

   // a key flips when its counter is one short of DEB_CYCLES and the sample still disagrees
   always_comb begin
      flip = '0;
      for (int i = 0; i < NKEYS; i++)
         flip[i] = sync2[i] != keys_level[i] && deb[i] == DLAST;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         sync1      <= '0;
         sync2      <= '0;
         keys_level <= '0;
         keys_press <= '0;
         for (int i = 0; i < NKEYS; i++)
            deb[i] <= '0;
      end else begin
         sync1      <= keys_in;
         sync2      <= sync1;
         keys_level <= keys_level ^ flip;
         keys_press <= flip & ~keys_level;
         for (int i = 0; i < NKEYS; i++)
            deb[i] <= (sync2[i] == keys_level[i] || flip[i]) ? '0 : deb[i] + 1'b1;
      end
   end

   // MSB-first replication; when narrowing, the same index map keeps the top bits
   for (genvar c = 0; c < 3; c++) begin : g_ch
      for (genvar j = 0; j < OUT_BPC; j++) begin : g_bit
         assign wide[c*OUT_BPC + OUT_BPC - 1 - j] = core_rgb[c*IN_BPC + IN_BPC - 1 - (j % IN_BPC)];
      end
   end

`ifdef WRAPPER_VIDEO_FRONTEND_BLANK_EN
   assign blank = core_hsync != SYNC_IDLE || core_vsync != SYNC_IDLE;
`else
   assign blank = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!reset) begin
         hsync       <= SYNC_IDLE;
         vsync       <= SYNC_IDLE;
         vsync_d     <= SYNC_IDLE;
         rgb         <= '0;
         frame_start <= 1'b0;
      end else begin
         if (pix_en) begin
            hsync <= core_hsync;
            vsync <= core_vsync;
            rgb   <= blank ? '0 : wide;
         end
         vsync_d     <= vsync;
         frame_start <= vsync_d == SYNC_IDLE && vsync != SYNC_IDLE;
      end
   end
endmodule

// File: tb/tb_wrapper_video_frontend.sv
// tb_wrapper_video_frontend: random and directed stimulus, per-cycle expectations queued by a reference model
// and popped by an independent monitor on the falling edge.
module tb_wrapper_video_frontend;
   localparam int CD = 3, NK = 4, DEB = 16, IB = 2, OB = 4;
   localparam bit IDLE = 1'b1;

   logic clk = 1'b0, reset = 1'b0;
   logic [NK-1:0] keys_in = '0;
   logic core_hsync = IDLE, core_vsync = IDLE;
   logic [3*IB-1:0] core_rgb = '0;
   logic pix_en, hsync, vsync, frame_start;
   logic [NK-1:0] keys_level, keys_press;
   logic [3*OB-1:0] rgb;

   typedef struct {
      logic pix, hs, vs, fs;
      logic [NK-1:0] lvl, prs;
      logic [3*OB-1:0] rgb;
   } exp_t;

   exp_t q[$];
   int checks = 0, fails = 0;

   always #5 clk = ~clk;

   wrapper_video_frontend #(
      .CLK_DIV(CD), .NKEYS(NK), .DEB_CYCLES(DEB),
      .IN_BPC(IB), .OUT_BPC(OB), .SYNC_IDLE(IDLE)
   ) dut (
      .clk(clk), .reset(reset), .keys_in(keys_in), .pix_en(pix_en),
      .keys_level(keys_level), .keys_press(keys_press),
      .core_hsync(core_hsync), .core_vsync(core_vsync), .core_rgb(core_rgb),
      .hsync(hsync), .vsync(vsync), .rgb(rgb), .frame_start(frame_start)
   );

   // channel widening straight from the rule: output bit j (MSB first) copies input bit j mod IB (MSB first)
   function automatic int widen(int v);
      int r = 0;
      for (int j = 0; j < OB; j++)
         r = r * 2 + ((v >> (IB - 1 - (j % IB))) & 1);
      return r;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s t=%0t actual=%h required=%h", name, $time, act, req);
      end
   endtask

   // reference model: one expected output set per rising edge
   initial begin
      int n, acc;
      bit all, blank;
      logic vs_old;
      logic [NK-1:0] s;
      logic [NK-1:0] pipe[$];
      logic [NK-1:0] hist[$];
      exp_t e, prev;
      n = 0;
      vs_old = IDLE;
      e.pix = 0; e.hs = IDLE; e.vs = IDLE; e.fs = 0; e.lvl = '0; e.prs = '0; e.rgb = '0;
      forever begin
         @(posedge clk);
         prev = e;
         if (!reset) begin
            n = 0;
            vs_old = IDLE;
            pipe = '{NK'(0), NK'(0)};
            hist.delete();
            e.pix = 0; e.hs = IDLE; e.vs = IDLE; e.fs = 0; e.lvl = '0; e.prs = '0; e.rgb = '0;
         end else begin
            n++;
            e.pix = (n % CD) == 0;
            s = pipe.pop_front();
            pipe.push_back(keys_in);
            hist.push_back(s);
            if (hist.size() > DEB) void'(hist.pop_front());
            e.prs = '0;
            // accept a change once the last DEB synchronised samples all disagree with the level
            for (int k = 0; k < NK; k++) begin
               all = hist.size() >= DEB;
               for (int t = 0; t < hist.size(); t++)
                  if (hist[t][k] == prev.lvl[k]) all = 0;
               if (all) begin
                  e.lvl[k] = ~prev.lvl[k];
                  e.prs[k] = ~prev.lvl[k];
               end
            end
`ifdef WRAPPER_VIDEO_FRONTEND_BLANK_EN
            blank = core_hsync != IDLE || core_vsync != IDLE;
`else
            blank = 0;
`endif
            if (prev.pix) begin
               e.hs = core_hsync;
               e.vs = core_vsync;
               acc = 0;
               for (int c = 0; c < 3; c++)
                  acc += widen((int'(core_rgb) >> (c * IB)) & ((1 << IB) - 1)) << (c * OB);
               e.rgb = blank ? '0 : (3*OB)'(acc);
            end
            e.fs = prev.vs != IDLE && vs_old == IDLE;
            vs_old = prev.vs;
         end
         q.push_back(e);
      end
   end

   // monitor
   initial begin
      exp_t x;
      forever begin
         @(negedge clk);
         if (q.size() != 0) begin
            x = q.pop_front();
            chk("pix_en", 32'(pix_en), 32'(x.pix));
            chk("keys_level", 32'(keys_level), 32'(x.lvl));
            chk("keys_press", 32'(keys_press), 32'(x.prs));
            chk("hsync", 32'(hsync), 32'(x.hs));
            chk("vsync", 32'(vsync), 32'(x.vs));
            chk("rgb", 32'(rgb), 32'(x.rgb));
            chk("frame_start", 32'(frame_start), 32'(x.fs));
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
         core_rgb = (3*IB)'($urandom);
         if ($urandom_range(0, 6) == 0) core_hsync = ~core_hsync;
         if ($urandom_range(0, 29) == 0) core_vsync = ~core_vsync;
      end
   endtask

   task automatic random_keys(input int segs);
      repeat (segs) begin
         keys_in = keys_in ^ NK'($urandom);
         tick($urandom_range(1, 40));
      end
   endtask

   initial begin
      tick(3);
      reset = 1'b1;
      // bounce on key 2, then a clean press
      for (int i = 0; i < 8; i++) begin
         keys_in[2] = ~keys_in[2];
         tick(5);
      end
      keys_in[2] = 1'b1;
      tick(40);
      keys_in[0] = 1'b1;
      keys_in[3] = 1'b1;
      tick(30);
      keys_in = '0;
      tick(30);
      random_keys(60);
      // reset for a single edge while keys are held and video runs
      keys_in = '1;
      tick(25);
      reset = 1'b0;
      tick(1);
      reset = 1'b1;
      tick(30);
      random_keys(40);
      @(negedge clk);
      #1;
      chk("queue_drained", 32'(q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule
